// File: rtl/ppr_pkg.sv
// ppr_pkg: shared types for the PPR top-k selector.
//   DATA_WIDTH / ADDR_WIDTH : score width and global node-id width.
//   cand_t                  : one (score, node id, valid) list entry.
//   topk_state_t            : scan/emit controller states.
//   cand_better(a, b)       : ranking order used by the sorted list.
package ppr_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 13;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] score;
        logic [ADDR_WIDTH-1:0] node_id;
        logic                  valid;
    } cand_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_INSERT = 2'd2,
        ST_EMIT   = 2'd3
    } topk_state_t;

    // A valid candidate ranks above any empty slot. Between two valid
    // entries the higher score wins and equal scores fall back to the
    // lower node id, so the result does not depend on scan order.
    function automatic logic cand_better(input cand_t a, input cand_t b);
        logic higher_score;
        logic tie_lower_id;
        higher_score = (a.score > b.score);
        tie_lower_id = (a.score == b.score) && (a.node_id < b.node_id);
        return a.valid && (!b.valid || higher_score || tie_lower_id);
    endfunction

endpackage

// File: rtl/topk_insert_list.sv
// topk_insert_list: TOPK-slot register list kept sorted best-first.
//   clk, rst  : clock, synchronous active-high reset (clears every slot).
//   clear     : invalidate every slot.
//   ins_en    : insert ins_cand at its ranked position (tail drops out).
//   ins_cand  : candidate entry.
//   pop       : drop slot 0 and shift the list up by one.
//   head      : slot 0.
//   count     : number of valid slots.
module topk_insert_list
    import ppr_pkg::*;
#(
    parameter int TOPK  = 4,
    parameter int CNT_W = $clog2(TOPK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ins_en,
    input  cand_t            ins_cand,
    input  logic             pop,
    output cand_t            head,
    output logic [CNT_W-1:0] count
);

    cand_t            slot_q [TOPK];
    cand_t            slot_d [TOPK];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next list contents: clear, ranked insert, or pop-and-shift.
    always_comb begin
        int  pos;
        logic found;
        for (int k = 0; k < TOPK; k++) begin
            slot_d[k] = slot_q[k];
        end
        count_d = count_q;
        pos     = 0;
        found   = 1'b0;
        if (clear) begin
            for (int k = 0; k < TOPK; k++) begin
                slot_d[k] = '0;
            end
            count_d = '0;
        end else if (ins_en) begin
            // Valid slots are contiguous from slot 0, so the first slot the
            // candidate beats is its rank; nothing beaten means discard.
            for (int k = 0; k < TOPK; k++) begin
                if (!found && cand_better(ins_cand, slot_q[k])) begin
                    found = 1'b1;
                    pos   = k;
                end
            end
            for (int k = 1; k < TOPK; k++) begin
                if (found && (k > pos)) begin
                    slot_d[k] = slot_q[k-1];
                end
            end
            for (int k = 0; k < TOPK; k++) begin
                if (found && (k == pos)) begin
                    slot_d[k]       = ins_cand;
                    slot_d[k].valid = 1'b1;
                end
            end
            if (found && (count_q != CNT_W'(TOPK))) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            for (int k = 0; k < TOPK - 1; k++) begin
                slot_d[k] = slot_q[k+1];
            end
            slot_d[TOPK-1] = '0;
            if (count_q != CNT_W'(0)) begin
                count_d = count_q - CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TOPK; k++) begin
                slot_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < TOPK; k++) begin
                slot_q[k] <= slot_d[k];
            end
            count_q <= count_d;
        end
    end

    assign head  = slot_q[0];
    assign count = count_q;

endmodule

// File: rtl/ppr_topk_select.sv
// ppr_topk_select: scans PARALLEL score-sum banks after start, keeps the
// TOPK best (score, node id) pairs and streams them out best first.
//   clk, rst     : clock, synchronous active-high reset.
//   start        : one-cycle pulse, accepted only in IDLE.
//   rd_addr/rd_en: bank read port (same address on every lane).
//   rd_data      : bank read data, one cycle after rd_en.
//   out_*        : valid/ready result stream; out_last flags the final entry.
//   busy / done  : activity flag and end-of-list pulse.
module ppr_topk_select
    import ppr_pkg::*;
#(
    parameter int PARALLEL = 4,
    parameter int NODE_NUM = 5,
    parameter int TOPK     = 4,
    parameter int SUM_BASE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [ADDR_WIDTH*PARALLEL-1:0] rd_addr,
    output logic [PARALLEL-1:0]            rd_en,
    input  logic [DATA_WIDTH*PARALLEL-1:0] rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_node_id,
    output logic [DATA_WIDTH-1:0]          out_score,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int LANE_W = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
    localparam int CNT_W  = $clog2(TOPK + 1);

    topk_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DATA_WIDTH-1:0] lat_q [PARALLEL];
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_en_q, out_valid_q, busy_q, done_q, done_d;
    logic                  clear_s, ins_en_s, pop_s, hs_s;
    cand_t                 cand_s, head_s;
    logic [CNT_W-1:0]      count_s;

    assign hs_s = out_valid_q && out_ready && head_s.valid;

    // Lane 0 comes straight from the bank; later lanes from the latches.
    always_comb begin
        cand_s         = '0;
        cand_s.valid   = 1'b1;
        cand_s.node_id = ADDR_WIDTH'(int'(lane_q) * NODE_NUM) + idx_q;
        if (lane_q == LANE_W'(0)) begin
            cand_s.score = rd_data[DATA_WIDTH-1:0];
        end else begin
            cand_s.score = lat_q[lane_q];
        end
    end

    // Controller next state and list control strobes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        clear_s  = 1'b0;
        ins_en_s = 1'b0;
        pop_s    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_s = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                lane_d  = '0;
                state_d = ST_INSERT;
            end
            ST_INSERT: begin
                ins_en_s = 1'b1;
                if (lane_q == LANE_W'(PARALLEL - 1)) begin
                    if (idx_q == ADDR_WIDTH'(NODE_NUM - 1)) begin
                        state_d = ST_EMIT;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            ST_EMIT: begin
                if (hs_s) begin
                    pop_s = 1'b1;
                    if (count_s == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, all decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            lane_q      <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            rd_en_q     <= (state_d == ST_ISSUE);
            if (state_d == ST_ISSUE) begin
                rd_addr_q <= ADDR_WIDTH'(SUM_BASE) + idx_d;
            end else begin
                rd_addr_q <= rd_addr_q;
            end
            out_valid_q <= (state_d == ST_EMIT);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    // Capture every lane in the first INSERT cycle, when rd_data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < PARALLEL; a++) begin
                lat_q[a] <= '0;
            end
        end else if ((state_q == ST_INSERT) && (lane_q == LANE_W'(0))) begin
            for (int a = 0; a < PARALLEL; a++) begin
                lat_q[a] <= rd_data[a*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int a = 0; a < PARALLEL; a++) begin
                lat_q[a] <= lat_q[a];
            end
        end
    end

    topk_insert_list #(
        .TOPK  (TOPK),
        .CNT_W (CNT_W)
    ) u_list (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .ins_en   (ins_en_s),
        .ins_cand (cand_s),
        .pop      (pop_s),
        .head     (head_s),
        .count    (count_s)
    );

    assign rd_addr     = {PARALLEL{rd_addr_q}};
    assign rd_en       = {PARALLEL{rd_en_q}};
    assign out_valid   = out_valid_q;
    assign out_node_id = head_s.node_id;
    assign out_score   = head_s.score;
    assign out_last    = out_valid_q && (count_s == CNT_W'(1));
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/ppr_topk_select.md
# ppr_topk_select

Downstream consumer of the quad diffusion top level. After all PARALLEL engines assert the combined finished condition (`finished_all`), this block scans the PARALLEL accumulated score-sum banks and keeps the TOPK highest-scoring nodes in a sorted register list. It then streams those nodes out over a valid/ready interface, highest score first. The output feeds the PS-side result FIFO/DMA that returns the PPR ranking.

## Interface
- DATA_WIDTH, 32, score width; scores are unsigned fixed-point.
- ADDR_WIDTH, 13, bank address width; also the width of the global node id.
- PARALLEL, 4, number of score-sum banks (one per diffusion engine).
- NODE_NUM, 5, nodes per bank.
- TOPK, 4, number of results retained (≥1).
- SUM_BASE, 0, first score-sum address in each bank.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, driven from `finished_all`.
- rd_addr  out  ADDR_WIDTH*PARALLEL  score-sum read address; the same value is driven in every lane slice.
- rd_en  out  PARALLEL  read enable, one bit per bank.
- rd_data  in  DATA_WIDTH*PARALLEL  bank read data; lane a occupies bits [(a+1)*DATA_WIDTH-1 : a*DATA_WIDTH]; valid 1 cycle after rd_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_node_id  out  ADDR_WIDTH  global node id = lane*NODE_NUM + local index.
- out_score  out  DATA_WIDTH  score of out_node_id.
- out_last  out  1  marks the final result of the list.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- States: IDLE, ISSUE, INSERT, EMIT.
- IDLE
  - On start, clear the list (all slot-valid bits = 0), set index i=0, go to ISSUE.
  - start is ignored in every other state.
- ISSUE (1 cycle)
  - Drive rd_addr = SUM_BASE+i and rd_en = all ones; go to INSERT with lane counter = 0.
- INSERT (PARALLEL cycles)
  - Cycle 0: latch all PARALLEL lanes of rd_data and insert lane 0 directly from rd_data.
  - Cycles 1..PARALLEL-1: insert lanes 1..PARALLEL-1 from the latches, one per cycle.
  - After lane PARALLEL-1: if i = NODE_NUM-1, go to EMIT; otherwise i++ and go to ISSUE.
- Insertion
  - Candidate (score, id) is compared against all TOPK slots in parallel.
  - Ordering key: higher score first; equal scores are ordered by lower node id first. This is independent of scan order.
  - The candidate goes in the first slot it beats. Lower slots shift down and the tail entry is dropped. It fills an empty slot if it beats nothing valid.
  - A candidate that beats nothing when the list is full is discarded.
  - Zero scores are legal candidates.
- EMIT
  - Present slot 0 on the outputs; the list shifts up on each out_valid&out_ready.
  - out_last = 1 when only one valid slot remains.
  - After the handshake of the last entry, pulse done and go to IDLE.
  - If NODE_NUM*PARALLEL < TOPK, only the filled slots are emitted.
- Compare width is DATA_WIDTH unsigned plus ADDR_WIDTH id. No arithmetic is performed on scores.

## Timing
- Reset values: out_valid=0, out_last=0, out_node_id=0, out_score=0, rd_en=0, rd_addr=0, busy=0, done=0. State returns to IDLE and all slots are invalidated.
- rst takes priority over start in the same cycle.
- rst in any state aborts the operation at the next edge; no done pulse is produced.
- Start is sampled at edge t; busy=1 and ISSUE begin in cycle t+1.
- Scan length is exactly NODE_NUM*(PARALLEL+1) cycles.
- First out_valid appears in cycle t+1+NODE_NUM*(PARALLEL+1).
- Each result costs 1 cycle when out_ready is held high.
- While out_valid=1 and out_ready=0, out_node_id, out_score and out_last are held stable.
- done asserts in the cycle after the final handshake, together with busy=0.
- rd_en is high only in ISSUE cycles. The block never writes the banks.

## Structure
- Package `ppr_pkg`:
  - `cand_t` struct {score[DATA_WIDTH], node_id[ADDR_WIDTH], valid}.
  - State enum `topk_state_t`.
  - Helper function `cand_better(a, b)` implementing the score/id ordering.
- Sub-module `topk_insert_list`:
  - TOPK-slot sorted register list.
  - Ports: clk, rst, clear, ins_en, ins_cand, pop, head, count.
  - The FSM and lane serialisation stay in `ppr_topk_select`.

## Test plan
- Distinct scores: lane values score = 10*node_id+7, NODE_NUM=5, PARALLEL=4, TOPK=4 -> ids 19, 18, 17, 16 emitted with scores 197..167; out_last on id 16; done one cycle after.
- Ties: all banks = 100 -> ids 0, 1, 2, 3, all with score 100.
- Unsigned extremes: node 7 = 0xFFFFFFFF, node 12 = 0x80000000, all others 0 -> order 7, 12, 0, 1.
- Backpressure: out_ready low for 3 cycles after the first valid -> outputs stable, no result lost or duplicated, 4 results total.
- Control: second start during INSERT is ignored, giving the same single result set. rst mid-INSERT -> all outputs 0 next cycle and no done pulse; a fresh start then gives the correct list.
- TOPK=32 with 20 nodes -> 20 results; out_last on the 20th.
